// File: rtl/mac_accumulator.sv
// Signed Q4.4 x Q4.4 multiply-accumulate into a saturating Q10.8 group sum; 2 cycles accept-to-out_valid.
// Backpressure only stalls input when a group's last beat waits in M behind an untaken output.
module mac_accumulator #(
  parameter int OP_W      = 8,
  parameter int ACC_W     = 18,
  parameter int FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  localparam int PROD_W = OP_W + FRAC_BITS;
  localparam int SUM_W  = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  logic              m_v, m_first, m_last;
  logic [PROD_W-1:0] m_p;
  logic [ACC_W-1:0]  acc;
  logic              sat_sticky, group_open;

  logic              hold, advance, accept;
  logic signed [PROD_W-1:0] a_ext, b_ext, prod;
  logic              start, clamp_flag, new_sticky;
  logic signed [SUM_W-1:0] p_ext, acc_ext, sum;
  logic [ACC_W-1:0]  clamped;

  // A finished sum in M may not overwrite an output the consumer has not taken.
  assign hold     = m_v & m_last & out_valid & ~out_ready;
  assign advance  = ~hold;
  assign in_ready = ~hold;
  assign accept   = in_valid & in_ready;

  assign a_ext = {{(PROD_W-OP_W){in_a[OP_W-1]}}, in_a};
  assign b_ext = {{(PROD_W-OP_W){in_b[OP_W-1]}}, in_b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v     <= 1'b0;
      m_p     <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else if (advance) begin
      m_v <= accept;
      if (accept) begin
        m_p     <= prod;
        m_first <= in_first;
        m_last  <= in_last;
      end
    end
  end

  always_comb begin
    start      = m_first | ~group_open;
    p_ext      = {{(SUM_W-PROD_W){m_p[PROD_W-1]}}, m_p};
    acc_ext    = {acc[ACC_W-1], acc};
    sum        = start ? p_ext : acc_ext + p_ext;
    clamped    = sum[ACC_W-1:0];
    clamp_flag = 1'b0;
    if (sum > SUM_MAX) begin
      clamped    = SUM_MAX[ACC_W-1:0];
      clamp_flag = 1'b1;
    end else if (sum < SUM_MIN) begin
      clamped    = SUM_MIN[ACC_W-1:0];
      clamp_flag = 1'b1;
    end
    new_sticky = (start ? 1'b0 : sat_sticky) | clamp_flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sat_sticky <= 1'b0;
      group_open <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (advance && m_v) begin
        acc        <= clamped;
        sat_sticky <= new_sticky;
        group_open <= ~m_last;
      end
      // A new load on the same edge as a transfer keeps out_valid high.
      if (advance && m_v && m_last) begin
        out_acc   <= clamped;
        out_sat   <= new_sticky;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: arithmetic reference model feeds an expected queue, monitor compares.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_first = 1'b0, in_last = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_acc;
  logic        out_sat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] exp_q[$];
  int          m_acc = 0;
  bit          m_open = 0, m_sticky = 0;
  logic [17:0] last_acc = '0;
  logic        last_sat = 1'b0;
  bit          rnd_rdy = 0, want_rdy = 1;

  mac_accumulator #(.OP_W(8), .ACC_W(18), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: group sum with clamping, computed from accepted beats in plain integers.
  task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input bit f, input bit l);
    int p, s;
    bit st, sat;
    p   = int'($signed(a)) * int'($signed(b));
    st  = f || !m_open;
    s   = st ? p : m_acc + p;
    sat = 0;
    if (s > 131071) begin s = 131071; sat = 1; end
    else if (s < -131072) begin s = -131072; sat = 1; end
    m_sticky = (st ? 1'b0 : m_sticky) | sat;
    m_acc    = s;
    if (l) begin
      exp_q.push_back({m_sticky, 18'(s)});
      m_open = 0;
    end else begin
      m_open = 1;
    end
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input bit f, input bit l);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      model_beat(a, b, f, l);
      #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic set_ready(input bit r);
    want_rdy = r;
    @(posedge clk); #2;
  endtask

  // out_ready driver: random during the soak phase, otherwise directed.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : want_rdy;
    end
  end

  // Monitor: compares every transfer against the queue, and checks hold stability.
  initial begin
    bit          held = 0;
    logic [17:0] h_acc;
    logic        h_sat;
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held && out_valid) begin
          check("hold_acc", out_acc, h_acc);
          check("hold_sat", out_sat, h_sat);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_acc", out_acc, e[17:0]);
            check("out_sat", out_sat, e[18]);
            last_acc = out_acc;
            last_sat = out_sat;
          end
        end
        held  = out_valid && !out_ready;
        h_acc = out_acc;
        h_sat = out_sat;
      end
    end
  end

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_sat", out_sat, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single 1.0 x 1.0 beat, latency and one-cycle pulse.
    send_beat(8'h10, 8'h10, 1, 1);
    @(negedge clk); check("lat_t1_valid", out_valid, 0);
    @(negedge clk); check("lat_t2_valid", out_valid, 1);
    check("single_acc", out_acc, 18'h00100);
    @(negedge clk); check("lat_t3_valid", out_valid, 0);
    drain();

    for (int i = 0; i < 9; i++) send_beat(8'h7F, 8'h7F, i == 0, i == 8);
    drain();
    check("pos_sat_acc", last_acc, 18'h1FFFF);
    check("pos_sat_flag", last_sat, 1);

    for (int i = 0; i < 4; i++) send_beat(8'h7F, 8'h7F, i == 0, i == 3);
    drain();
    check("four_acc", last_acc, 18'h0FC04);
    check("four_sat", last_sat, 0);

    for (int i = 0; i < 9; i++) send_beat(8'h80, 8'h7F, i == 0, i == 8);
    drain();
    check("neg_sat_acc", last_acc, 18'h20000);
    check("neg_sat_flag", last_sat, 1);
    send_beat(8'h10, 8'hF0, 1, 1);
    drain();
    check("neg_one_acc", last_acc, 18'h3FF00);
    check("sticky_clear", last_sat, 0);

    // Back-to-back groups against a stalled consumer.
    set_ready(0);
    send_beat(8'h10, 8'h10, 1, 0);
    send_beat(8'h10, 8'h10, 0, 1);
    send_beat(8'h10, 8'h10, 1, 0);
    send_beat(8'h10, 8'h20, 0, 1);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_acc", out_acc, 18'h00200);
    repeat (3) @(negedge clk);
    check("bp_still_acc", out_acc, 18'h00200);
    @(posedge clk); #1;
    set_ready(1);
    drain();
    check("bp_second_acc", last_acc, 18'h00300);

    // Restart on in_first mid-group.
    for (int i = 0; i < 3; i++) send_beat(8'h10, 8'h10, i == 0, 0);
    send_beat(8'h20, 8'h10, 1, 1);
    drain();
    check("restart_acc", last_acc, 18'h00200);

    // Async reset with an output pending and a group open.
    set_ready(0);
    send_beat(8'h30, 8'h10, 1, 1);
    send_beat(8'h10, 8'h10, 1, 0);
    repeat (2) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_acc", out_acc, 0);
    check("async_out_sat", out_sat, 0);
    exp_q.delete();
    m_acc = 0; m_open = 0; m_sticky = 0;
    want_rdy = 1;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(8'h20, 8'h30, 0, 1);
    drain();
    check("post_rst_acc", last_acc, 18'h00600);

    // Randomized soak with random backpressure.
    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      send_beat(8'($urandom), 8'($urandom), $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0 || i == 399);
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end
    rnd_rdy = 0;
    drain();
    repeat (3) @(negedge clk);
    check("final_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
